furv_bus_arbiter: RTL and testbench
===================================

Name: furv_bus_arbiter

Overview:
- Shares one single-port memory bus between the core's instruction-fetch requester (master 0) and its load/store requester (master 1).
- Master 1 uses the core's data-port semantics: word address, byte selects, write enable and a one-cycle ack.
- Grants go round-robin on contention, one transfer per grant.
- Stuck transfers are aborted by a watchdog that returns an error pulse to the requester.

Parameters:
- ADDR_WIDTH, 30, word-address width of all address ports.
- DATA_WIDTH, 32, data bus width; SEL width is DATA_WIDTH/8.
- TIMEOUT, 255, cycles a granted transfer may wait for s_ack before it is aborted; 0 disables the watchdog.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- m0_req  in  1  fetch request; held high until m0_ack or m0_err.
- m0_addr  in  ADDR_WIDTH  fetch word address.
- m0_rdata  out  DATA_WIDTH  fetched word; equals s_rdata, valid when m0_ack=1.
- m0_ack  out  1  fetch complete, one-cycle pulse.
- m0_err  out  1  fetch timed out, one-cycle pulse.
- m1_req  in  1  data request; held high until m1_ack or m1_err.
- m1_we  in  1  1 = store.
- m1_addr  in  ADDR_WIDTH  data word address.
- m1_sel  in  DATA_WIDTH/8  byte lane enables.
- m1_wdata  in  DATA_WIDTH  store data, already lane-shifted.
- m1_rdata  out  DATA_WIDTH  load data; equals s_rdata.
- m1_ack  out  1  data transfer complete, one-cycle pulse.
- m1_err  out  1  data transfer timed out, one-cycle pulse.
- s_cyc  out  1  bus cycle active.
- s_we  out  1  write enable to memory.
- s_addr  out  ADDR_WIDTH  memory word address.
- s_sel  out  DATA_WIDTH/8  memory byte enables.
- s_wdata  out  DATA_WIDTH  memory write data.
- s_rdata  in  DATA_WIDTH  memory read data.
- s_ack  in  1  memory completes the current cycle.

Behaviour:
- States: IDLE, GNT0, GNT1; state is registered.
- Priority bit `last` records the most recently served master.

Reset:
- state=IDLE, last=1 (master 0 wins the first tie), watchdog count=0.
- All outputs 0: s_cyc, s_we, s_addr, s_sel, s_wdata, m*_ack, m*_err.

IDLE:
- s_cyc=0 and all s_* outputs 0.
- Only m0_req: next state GNT0.
- Only m1_req: next state GNT1.
- Both requests: grant the master that is not `last`.
- No request: stay in IDLE.

GNTx:
- s_cyc=1. s_* outputs follow master x's inputs combinationally.
- For master 0: s_we=0, s_sel=all ones, s_wdata=0.
- Latency: a request seen in IDLE at edge N has s_cyc high from cycle N+1.

Completion:
- s_ack=1 in GNTx gives mx_ack=1 in the same cycle (combinational).
- Next edge: state=IDLE, last=x, count=0.
- One IDLE turnaround cycle always separates grants; there is no back-to-back chaining.

Ack gating:
- s_ack while in IDLE is ignored; neither mx_ack fires.
- m0_ack and m1_ack are never high together.

Abort:
- If mx_req drops while in GNTx with s_ack=0, s_cyc falls combinationally.
- Next edge: IDLE with no ack and no err; `last` is not updated.

Watchdog:
- count increments every GNTx cycle without s_ack.
- When count==TIMEOUT-1 and s_ack=0: mx_err=1 that cycle, then IDLE next edge, last=x, count=0.
- s_ack in the same cycle as the limit takes precedence: ack, no err.
- The counter saturates and is unused when TIMEOUT=0.

Other rules:
- m0_rdata and m1_rdata are always driven from s_rdata; they are qualified only by the ack.
- Reset asserted mid-transfer forces IDLE on that edge, and s_cyc is low the following cycle.
- The pending ack is lost; the requester re-issues after reset.
- The counter width is sized to hold TIMEOUT (minimum 1 bit).

Test Plan:
- Single fetch: m0_req=1, m0_addr=0x10, memory acks 2 cycles after s_cyc -> s_addr=0x10, s_sel=4'b1111, s_we=0; m0_ack pulses once with m0_rdata=s_rdata; IDLE one cycle later.
- Contention after reset: m0_req=m1_req=1 held -> grant order 0,1,0,1 across four transfers, each separated by one IDLE cycle; m1 store shows s_we=1, s_sel=m1_sel=4'b0100, s_wdata=m1_wdata.
- Timeout: TIMEOUT=4, m1 granted, s_ack never asserted -> m1_err high in the 4th GNT1 cycle, then s_cyc=0; a following m0 request is granted next.
- Ack at the limit: TIMEOUT=4, s_ack in the 4th GNT1 cycle -> m1_ack=1, m1_err=0.
- Abort: m0 granted, m0_req drops before s_ack -> s_cyc=0 in the same cycle, no m0_ack or m0_err; a later contention with m1 still grants m0 first (last unchanged).
- Reset mid-transfer: rst=1 during GNT1 -> next cycle s_cyc=0, all acks/errs 0; after release, a simultaneous request grants m0 first.

Source files
------------

// File: rtl/furv_bus_arbiter.sv
// Round-robin arbiter sharing one single-port memory bus between the fetch
// requester (m0) and the load/store requester (m1), with a stuck-transfer watchdog.
module furv_bus_arbiter #(
    parameter int ADDR_WIDTH = 30,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    m0_req,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    output logic [DATA_WIDTH-1:0]   m0_rdata,
    output logic                    m0_ack,
    output logic                    m0_err,
    input  logic                    m1_req,
    input  logic                    m1_we,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH/8-1:0] m1_sel,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    output logic [DATA_WIDTH-1:0]   m1_rdata,
    output logic                    m1_ack,
    output logic                    m1_err,
    output logic                    s_cyc,
    output logic                    s_we,
    output logic [ADDR_WIDTH-1:0]   s_addr,
    output logic [DATA_WIDTH/8-1:0] s_sel,
    output logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH-1:0]   s_rdata,
    input  logic                    s_ack
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t          state;
    logic            last;
    logic [CW-1:0]   count;
    logic            gnt0, gnt1, granted, cur_req, at_limit, timeout;

    assign gnt0     = (state == GNT0);
    assign gnt1     = (state == GNT1);
    assign granted  = gnt0 | gnt1;
    assign cur_req  = (gnt0 & m0_req) | (gnt1 & m1_req);
    assign at_limit = (TIMEOUT != 0) && (count == CW'(TIMEOUT - 1));
    // A dropped request is an abort, never a timeout, even at the limit.
    assign timeout  = cur_req & ~s_ack & at_limit;

    assign s_cyc    = cur_req;
    assign m0_ack   = gnt0 & s_ack;
    assign m1_ack   = gnt1 & s_ack;
    assign m0_err   = gnt0 & timeout;
    assign m1_err   = gnt1 & timeout;
    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;

    always_comb begin
        s_we    = 1'b0;
        s_addr  = '0;
        s_sel   = '0;
        s_wdata = '0;
        case (state)
            GNT0: begin
                s_addr = m0_addr;
                s_sel  = '1;
            end
            GNT1: begin
                s_we    = m1_we;
                s_addr  = m1_addr;
                s_sel   = m1_sel;
                s_wdata = m1_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    count <= '0;
                    // On a tie, the master not served most recently wins.
                    if (m0_req && (!m1_req || last))
                        state <= GNT0;
                    else if (m1_req)
                        state <= GNT1;
                end
                default: begin
                    if (s_ack || timeout) begin
                        state <= IDLE;
                        last  <= gnt1;
                        count <= '0;
                    end else if (!cur_req) begin
                        state <= IDLE;
                        count <= '0;
                    end else if (count != '1) begin
                        count <= count + CW'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_furv_bus_arbiter.sv
// Randomized and directed checks of furv_bus_arbiter against a cycle-level
// behavioural model of the grant/ack/timeout rules.
module tb_furv_bus_arbiter;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_ack, m0_err;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_rdata;
    logic          m1_req, m1_we, m1_ack, m1_err;
    logic [AW-1:0] m1_addr;
    logic [SW-1:0] m1_sel;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic          s_cyc, s_we, s_ack;
    logic [AW-1:0] s_addr;
    logic [SW-1:0] s_sel;
    logic [DW-1:0] s_wdata, s_rdata;

    furv_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_sel(m1_sel), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_cyc(s_cyc), .s_we(s_we), .s_addr(s_addr), .s_sel(s_sel), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ack(s_ack)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Model: which master owns the bus (-1 none), who was served last,
    // and how many granted cycles have gone by without an ack.
    int own = -1;
    int last_srv = 1;
    int waited = 0;
    int served[$];
    int n_err = 0;
    bit done0, done1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit q0, input bit q1, input bit sa);
        bit e_req, e_ack0, e_ack1, e_lim;
        logic [AW-1:0] e_addr;
        logic [SW-1:0] e_sel;
        logic [DW-1:0] e_wdata;
        logic          e_we;
        rst = r; m0_req = q0; m1_req = q1; s_ack = sa; s_rdata = $urandom;
        #1;
        e_req   = (own == 0) ? q0 : (own == 1) ? q1 : 1'b0;
        e_ack0  = (own == 0) && sa;
        e_ack1  = (own == 1) && sa;
        e_lim   = (own >= 0) && e_req && !sa && (waited == TO - 1);
        e_we    = (own == 1) ? m1_we : 1'b0;
        e_addr  = (own == 0) ? m0_addr : (own == 1) ? m1_addr : '0;
        e_sel   = (own == 0) ? '1 : (own == 1) ? m1_sel : '0;
        e_wdata = (own == 1) ? m1_wdata : '0;
        chk("s_cyc", s_cyc, e_req);
        chk("s_we", s_we, e_we);
        chk("s_addr", s_addr, e_addr);
        chk("s_sel", s_sel, e_sel);
        chk("s_wdata", s_wdata, e_wdata);
        chk("m0_ack", m0_ack, e_ack0);
        chk("m1_ack", m1_ack, e_ack1);
        chk("m0_err", m0_err, e_lim && own == 0);
        chk("m1_err", m1_err, e_lim && own == 1);
        chk("m0_rdata", m0_rdata, s_rdata);
        chk("m1_rdata", m1_rdata, s_rdata);
        if (m0_ack) served.push_back(0);
        if (m1_ack) served.push_back(1);
        if (m0_err || m1_err) n_err++;
        done0 = (own == 0) && (sa || e_lim);
        done1 = (own == 1) && (sa || e_lim);
        if (r) begin
            own = -1; last_srv = 1; waited = 0;
        end else if (own < 0) begin
            waited = 0;
            if (q0 && q1)  own = (last_srv == 1) ? 0 : 1;
            else if (q0)   own = 0;
            else if (q1)   own = 1;
        end else if (sa || e_lim) begin
            last_srv = own; own = -1; waited = 0;
        end else if (!e_req) begin
            own = -1; waited = 0;
        end else begin
            waited++;
        end
        @(negedge clk);
    endtask

    initial begin
        bit q0, q1, sa, r;
        rst = 1'b1; m0_req = 0; m1_req = 0; s_ack = 0; s_rdata = '0;
        m0_addr = '0; m1_we = 0; m1_addr = '0; m1_sel = '0; m1_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // reset state, then a single fetch acked two cycles after s_cyc
        step(1, 0, 0, 0);
        m0_addr = AW'(32'h10);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        served.delete();
        step(0, 1, 0, 1);
        chk("fetch_ack", served.size(), 1);
        step(0, 0, 0, 0);

        // contention after reset: 0,1,0,1
        m1_we = 1; m1_sel = 4'b0100; m1_wdata = 32'hCAFE_F00D; m1_addr = AW'(32'h2A0);
        step(1, 0, 0, 0);
        served.delete();
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 1, 0);
            step(0, 1, 1, 1);
        end
        chk("order_n", served.size(), 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("order%0d", k), (served.size() > k) ? served[k] : 9, k % 2);

        // timeout on m1, then m0 is granted next
        step(0, 0, 0, 0);
        n_err = 0; served.delete();
        step(0, 0, 1, 0);
        for (int k = 0; k < TO; k++) step(0, 0, 1, 0);
        chk("to_err", n_err, 1);
        step(0, 1, 0, 0);
        step(0, 1, 0, 1);
        chk("to_next", (served.size() == 1) ? served[0] : 9, 0);

        // ack on the limit cycle wins over the timeout
        n_err = 0; served.delete();
        step(0, 0, 1, 0);
        for (int k = 0; k < TO - 1; k++) step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        chk("lim_ack", served.size(), 1);
        chk("lim_err", n_err, 0);
        step(0, 0, 0, 0);

        // abort leaves priority untouched: m0 still first on contention
        step(1, 0, 0, 0);
        served.delete(); n_err = 0;
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 1, 0);
        step(0, 1, 1, 1);
        chk("abort_first", (served.size() == 1) ? served[0] : 9, 0);
        chk("abort_err", n_err, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        step(0, 0, 0, 0);

        // reset during GNT1
        served.delete();
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        step(0, 1, 1, 0);
        step(0, 1, 1, 1);
        chk("rst_first", (served.size() == 1) ? served[0] : 9, 0);

        // randomized traffic
        q0 = 0; q1 = 0; done0 = 0; done1 = 0;
        for (int i = 0; i < 3000; i++) begin
            if (done0) q0 = 0;
            else if (!q0 && $urandom_range(2) == 0) begin
                q0 = 1; m0_addr = AW'($urandom);
            end
            if (done1) q1 = 0;
            else if (!q1 && $urandom_range(2) == 0) begin
                q1 = 1; m1_addr = AW'($urandom); m1_we = 1'($urandom);
                m1_sel = SW'($urandom); m1_wdata = $urandom;
            end
            sa = ($urandom_range(2) == 0);
            if (own == 0 && q0 && $urandom_range(24) == 0) begin q0 = 0; sa = 0; end
            if (own == 1 && q1 && $urandom_range(24) == 0) begin q1 = 0; sa = 0; end
            r = ($urandom_range(299) == 0);
            step(r, q0, q1, sa);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
